// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, ALU-side and response signals for alu_share_arbiter.
// slave: the arbiter's view; master: the surrounding requesters/ALU/bench.
interface alu_share_arbiter_if;
   logic        req0_valid_i;
   logic        req0_ready_o;
   logic [31:0] req0_data1_i;
   logic [31:0] req0_data2_i;
   logic [2:0]  req0_ctrl_i;
   logic        req1_valid_i;
   logic        req1_ready_o;
   logic [31:0] req1_data1_i;
   logic [31:0] req1_data2_i;
   logic [2:0]  req1_ctrl_i;
   logic [31:0] alu_data1_o;
   logic [31:0] alu_data2_o;
   logic [2:0]  alu_ctrl_o;
   logic [31:0] alu_result_i;
   logic        rsp0_valid_o;
   logic        rsp1_valid_o;
   logic [31:0] rsp_data_o;
   logic        rsp_zero_o;
   logic        busy_o;

   modport slave (
      input  req0_valid_i, req0_data1_i, req0_data2_i, req0_ctrl_i,
      input  req1_valid_i, req1_data1_i, req1_data2_i, req1_ctrl_i,
      input  alu_result_i,
      output req0_ready_o, req1_ready_o,
      output alu_data1_o, alu_data2_o, alu_ctrl_o,
      output rsp0_valid_o, rsp1_valid_o, rsp_data_o, rsp_zero_o, busy_o
   );

   modport master (
      output req0_valid_i, req0_data1_i, req0_data2_i, req0_ctrl_i,
      output req1_valid_i, req1_data1_i, req1_data2_i, req1_ctrl_i,
      output alu_result_i,
      input  req0_ready_o, req1_ready_o,
      input  alu_data1_o, alu_data2_o, alu_ctrl_o,
      input  rsp0_valid_o, rsp1_valid_o, rsp_data_o, rsp_zero_o, busy_o
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Winning operands are registered and held for the op latency (MUL_LAT for
// multiply, one cycle otherwise); the result is captured into a response
// register with a one-cycle valid pulse to the owning requester.
module alu_share_arbiter #(
   parameter int unsigned MUL_LAT = 3,
   parameter int unsigned CNT_W   = 4
) (
   input logic               clk_i,
   input logic               rst_i,
   alu_share_arbiter_if.slave bus
);

   typedef enum logic {IDLE, EXEC} state_t;

   localparam logic [2:0] CTRL_MUL = 3'b100;

   state_t             state_q, state_d;
   logic               last_grant_q;
   logic               owner_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [31:0]        alu_data1_q, alu_data2_q;
   logic [2:0]         alu_ctrl_q;
   logic [31:0]        rsp_data_q;
   logic               rsp_zero_q;
   logic               rsp0_valid_q, rsp1_valid_q;

   logic               grant0, grant1;
   logic               ready0, ready1;
   logic               accept;
   logic               complete;
   logic [31:0]        win_data1, win_data2;
   logic [2:0]         win_ctrl;
   logic [CNT_W-1:0]   cnt_load;

   // Round-robin grant: a lone valid wins, a tie goes opposite last_grant.
   always_comb begin
      grant0 = bus.req0_valid_i & (~bus.req1_valid_i | last_grant_q);
      grant1 = bus.req1_valid_i & (~bus.req0_valid_i | ~last_grant_q);
      ready0 = (state_q == IDLE) & grant0;
      ready1 = (state_q == IDLE) & grant1;
      accept = ready0 | ready1;
      complete = (state_q == EXEC) && (cnt_q == '0);
      win_data1 = ready1 ? bus.req1_data1_i : bus.req0_data1_i;
      win_data2 = ready1 ? bus.req1_data2_i : bus.req0_data2_i;
      win_ctrl  = ready1 ? bus.req1_ctrl_i  : bus.req0_ctrl_i;
      cnt_load  = (win_ctrl == CTRL_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
   end

   // Next-state logic: accept moves to EXEC, counter expiry returns to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)   state_d = EXEC;
         EXEC:    if (complete) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Operand capture, latency counter and grant history.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         alu_data1_q  <= '0;
         alu_data2_q  <= '0;
         alu_ctrl_q   <= '0;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
      end else if (accept) begin
         alu_data1_q  <= win_data1;
         alu_data2_q  <= win_data2;
         alu_ctrl_q   <= win_ctrl;
         cnt_q        <= cnt_load;
         last_grant_q <= ready1;
         owner_q      <= ready1;
      end else if ((state_q == EXEC) && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   // Response capture; valid pulses are cleared on every non-completing edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_data_q   <= '0;
         rsp_zero_q   <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
      end else begin
         rsp0_valid_q <= complete & ~owner_q;
         rsp1_valid_q <= complete & owner_q;
         if (complete) begin
            rsp_data_q <= bus.alu_result_i;
            rsp_zero_q <= (bus.alu_result_i == '0);
         end
      end
   end

   assign bus.req0_ready_o = ready0;
   assign bus.req1_ready_o = ready1;
   assign bus.alu_data1_o  = alu_data1_q;
   assign bus.alu_data2_o  = alu_data2_q;
   assign bus.alu_ctrl_o   = alu_ctrl_q;
   assign bus.rsp0_valid_o = rsp0_valid_q;
   assign bus.rsp1_valid_o = rsp1_valid_q;
   assign bus.rsp_data_o   = rsp_data_q;
   assign bus.rsp_zero_o   = rsp_zero_q;
   assign bus.busy_o       = (state_q == EXEC);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed testbench for alu_share_arbiter with a behavioural ALU model.
module tb_alu_share_arbiter;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   alu_share_arbiter_if bus ();

   alu_share_arbiter #(.MUL_LAT(3), .CNT_W(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: 000 add, 001 sub, 010 and, 011 or, 100 mul, 101 sll, 110 srl, 111 xor.
   always_comb begin
      case (bus.alu_ctrl_o)
         3'b000:  bus.alu_result_i = bus.alu_data1_o + bus.alu_data2_o;
         3'b001:  bus.alu_result_i = bus.alu_data1_o - bus.alu_data2_o;
         3'b010:  bus.alu_result_i = bus.alu_data1_o & bus.alu_data2_o;
         3'b011:  bus.alu_result_i = bus.alu_data1_o | bus.alu_data2_o;
         3'b100:  bus.alu_result_i = bus.alu_data1_o * bus.alu_data2_o;
         3'b101:  bus.alu_result_i = bus.alu_data1_o << bus.alu_data2_o[4:0];
         3'b110:  bus.alu_result_i = bus.alu_data1_o >> bus.alu_data2_o[4:0];
         default: bus.alu_result_i = bus.alu_data1_o ^ bus.alu_data2_o;
      endcase
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
      bus.req0_valid_i = v; bus.req0_data1_i = a; bus.req0_data2_i = b; bus.req0_ctrl_i = c;
   endtask

   task automatic set_req1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
      bus.req1_valid_i = v; bus.req1_data1_i = a; bus.req1_data2_i = b; bus.req1_ctrl_i = c;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      set_req0(1'b0, '0, '0, '0);
      set_req1(1'b0, '0, '0, '0);
      tick; tick;
      @(negedge clk);
      n_checks++; if (bus.alu_data1_o !== 32'd0) begin n_fail++; $display("FAIL rst_alu_data1: got %h want 0", bus.alu_data1_o); end
      n_checks++; if (bus.alu_data2_o !== 32'd0) begin n_fail++; $display("FAIL rst_alu_data2: got %h want 0", bus.alu_data2_o); end
      n_checks++; if (bus.alu_ctrl_o !== 3'd0) begin n_fail++; $display("FAIL rst_alu_ctrl: got %h want 0", bus.alu_ctrl_o); end
      n_checks++; if (bus.rsp_data_o !== 32'd0) begin n_fail++; $display("FAIL rst_rsp_data: got %h want 0", bus.rsp_data_o); end
      n_checks++; if (bus.rsp_zero_o !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_zero: got %b want 0", bus.rsp_zero_o); end
      n_checks++; if ({bus.rsp0_valid_o, bus.rsp1_valid_o} !== 2'b00) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 00", {bus.rsp0_valid_o, bus.rsp1_valid_o}); end
      n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy_o); end
      n_checks++; if ({bus.req0_ready_o, bus.req1_ready_o} !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b want 00", {bus.req0_ready_o, bus.req1_ready_o}); end
      tick;
      rst = 1'b0;
      set_req0(1'b1, 32'd5, 32'd7, 3'b000);
      @(negedge clk);
      n_checks++; if ({bus.req0_ready_o, bus.req1_ready_o} !== 2'b10) begin n_fail++; $display("FAIL add_ready: got %b want 10", {bus.req0_ready_o, bus.req1_ready_o}); end
      tick;
      set_req0(1'b0, '0, '0, '0);
      @(negedge clk);
      n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL add_busy: got %b want 1", bus.busy_o); end
      n_checks++; if ({bus.alu_data1_o, bus.alu_data2_o} !== {32'd5, 32'd7}) begin n_fail++; $display("FAIL add_operands: got %h %h want 5 7", bus.alu_data1_o, bus.alu_data2_o); end
      n_checks++; if (bus.rsp0_valid_o !== 1'b0) begin n_fail++; $display("FAIL add_early_rsp: got %b want 0", bus.rsp0_valid_o); end
      tick;
      @(negedge clk);
      n_checks++; if (bus.rsp0_valid_o !== 1'b1) begin n_fail++; $display("FAIL add_rsp0: got %b want 1", bus.rsp0_valid_o); end
      n_checks++; if (bus.rsp1_valid_o !== 1'b0) begin n_fail++; $display("FAIL add_rsp1: got %b want 0", bus.rsp1_valid_o); end
      n_checks++; if (bus.rsp_data_o !== 32'd12) begin n_fail++; $display("FAIL add_data: got %h want c", bus.rsp_data_o); end
      n_checks++; if (bus.rsp_zero_o !== 1'b0) begin n_fail++; $display("FAIL add_zero: got %b want 0", bus.rsp_zero_o); end
      n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL add_idle: got %b want 0", bus.busy_o); end
   endtask

   task automatic test_round_robin;
      logic prev;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      set_req0(1'b1, 32'd9, 32'd9, 3'b001);
      set_req1(1'b1, 32'd20, 32'd3, 3'b001);
      prev = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++; if ({bus.req0_ready_o, bus.req1_ready_o} !== (((i % 2) == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_grant%0d: got %b", i, {bus.req0_ready_o, bus.req1_ready_o}); end
         if (i > 0) begin
            n_checks++; if ({bus.rsp0_valid_o, bus.rsp1_valid_o} !== (prev ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL rr_rsp%0d: got %b owner %b", i, {bus.rsp0_valid_o, bus.rsp1_valid_o}, prev); end
            n_checks++; if ({bus.rsp_zero_o, bus.rsp_data_o} !== (prev ? {1'b0, 32'd17} : {1'b1, 32'd0})) begin n_fail++; $display("FAIL rr_data%0d: got %b %h", i, bus.rsp_zero_o, bus.rsp_data_o); end
         end
         prev = ((i % 2) == 1);
         tick;
         @(negedge clk);
         n_checks++; if ({bus.busy_o, bus.req0_ready_o, bus.req1_ready_o} !== 3'b100) begin n_fail++; $display("FAIL rr_exec%0d: got %b want 100", i, {bus.busy_o, bus.req0_ready_o, bus.req1_ready_o}); end
         tick;
      end
      set_req0(1'b0, '0, '0, '0);
      set_req1(1'b0, '0, '0, '0);
      @(negedge clk);
      n_checks++; if ({bus.rsp0_valid_o, bus.rsp1_valid_o} !== 2'b01) begin n_fail++; $display("FAIL rr_last_rsp: got %b want 01", {bus.rsp0_valid_o, bus.rsp1_valid_o}); end
      n_checks++; if (bus.rsp_data_o !== 32'd17) begin n_fail++; $display("FAIL rr_last_data: got %h want 11", bus.rsp_data_o); end
   endtask

   task automatic test_multiply;
      tick;
      set_req1(1'b1, 32'd6, 32'd7, 3'b100);
      @(negedge clk);
      n_checks++; if ({bus.req0_ready_o, bus.req1_ready_o} !== 2'b01) begin n_fail++; $display("FAIL mul_ready: got %b want 01", {bus.req0_ready_o, bus.req1_ready_o}); end
      tick;
      set_req1(1'b0, '0, '0, '0);
      set_req0(1'b1, 32'd1, 32'd2, 3'b000);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         n_checks++; if ({bus.busy_o, bus.req0_ready_o, bus.rsp1_valid_o} !== 3'b100) begin n_fail++; $display("FAIL mul_hold%0d: busy/ready0/rsp1 got %b want 100", k, {bus.busy_o, bus.req0_ready_o, bus.rsp1_valid_o}); end
         n_checks++; if ({bus.alu_data1_o, bus.alu_data2_o, bus.alu_ctrl_o} !== {32'd6, 32'd7, 3'b100}) begin n_fail++; $display("FAIL mul_operands%0d: got %h %h %b", k, bus.alu_data1_o, bus.alu_data2_o, bus.alu_ctrl_o); end
         tick;
      end
      @(negedge clk);
      n_checks++; if (bus.rsp1_valid_o !== 1'b1) begin n_fail++; $display("FAIL mul_rsp1: got %b want 1", bus.rsp1_valid_o); end
      n_checks++; if (bus.rsp_data_o !== 32'd42) begin n_fail++; $display("FAIL mul_data: got %h want 2a", bus.rsp_data_o); end
      n_checks++; if (bus.req0_ready_o !== 1'b1) begin n_fail++; $display("FAIL mul_follow_ready: got %b want 1", bus.req0_ready_o); end
      tick;
      set_req0(1'b0, '0, '0, '0);
      @(negedge clk);
      n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL mul_follow_busy: got %b want 1", bus.busy_o); end
      tick;
      @(negedge clk);
      n_checks++; if ({bus.rsp0_valid_o, bus.rsp_data_o} !== {1'b1, 32'd3}) begin n_fail++; $display("FAIL mul_follow_rsp: got %b %h want 1 3", bus.rsp0_valid_o, bus.rsp_data_o); end
   endtask

   task automatic test_back_to_back;
      tick;
      set_req0(1'b1, 32'hFF, 32'h0F, 3'b111);
      @(negedge clk);
      n_checks++; if (bus.req0_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %b want 1", bus.req0_ready_o); end
      tick;
      set_req0(1'b1, 32'hF0, 32'h3C, 3'b010);
      @(negedge clk);
      n_checks++; if ({bus.req0_ready_o, bus.rsp0_valid_o} !== 2'b00) begin n_fail++; $display("FAIL b2b_gap: ready0/rsp0 got %b want 00", {bus.req0_ready_o, bus.rsp0_valid_o}); end
      tick;
      @(negedge clk);
      n_checks++; if ({bus.rsp0_valid_o, bus.rsp_data_o} !== {1'b1, 32'hF0}) begin n_fail++; $display("FAIL b2b_rsp1: got %b %h want 1 f0", bus.rsp0_valid_o, bus.rsp_data_o); end
      n_checks++; if (bus.req0_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready2: got %b want 1", bus.req0_ready_o); end
      tick;
      set_req0(1'b0, '0, '0, '0);
      @(negedge clk);
      n_checks++; if ({bus.rsp0_valid_o, bus.rsp_data_o} !== {1'b0, 32'hF0}) begin n_fail++; $display("FAIL b2b_pulse1: got %b %h want 0 f0", bus.rsp0_valid_o, bus.rsp_data_o); end
      tick;
      @(negedge clk);
      n_checks++; if ({bus.rsp0_valid_o, bus.rsp_data_o} !== {1'b1, 32'h30}) begin n_fail++; $display("FAIL b2b_rsp2: got %b %h want 1 30", bus.rsp0_valid_o, bus.rsp_data_o); end
      tick;
      @(negedge clk);
      n_checks++; if ({bus.rsp0_valid_o, bus.rsp_data_o} !== {1'b0, 32'h30}) begin n_fail++; $display("FAIL b2b_pulse2: got %b %h want 0 30", bus.rsp0_valid_o, bus.rsp_data_o); end
   endtask

   task automatic test_reset_mid_mul;
      tick;
      set_req0(1'b1, 32'd3, 32'd4, 3'b100);
      @(negedge clk);
      n_checks++; if (bus.req0_ready_o !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", bus.req0_ready_o); end
      tick;
      set_req0(1'b0, '0, '0, '0);
      @(negedge clk);
      n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL abort_busy: got %b want 1", bus.busy_o); end
      tick;
      rst = 1'b1;
      #1;
      n_checks++; if ({bus.busy_o, bus.alu_data1_o, bus.alu_ctrl_o} !== {1'b0, 32'd0, 3'd0}) begin n_fail++; $display("FAIL abort_async: got %b %h %b", bus.busy_o, bus.alu_data1_o, bus.alu_ctrl_o); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_checks++; if ({bus.rsp0_valid_o, bus.rsp1_valid_o} !== 2'b00) begin n_fail++; $display("FAIL abort_no_rsp%0d: got %b want 00", k, {bus.rsp0_valid_o, bus.rsp1_valid_o}); end
         tick;
         if (k == 1) rst = 1'b0;
      end
      set_req0(1'b1, 32'd1, 32'd1, 3'b000);
      set_req1(1'b1, 32'd2, 32'd2, 3'b000);
      @(negedge clk);
      n_checks++; if ({bus.req0_ready_o, bus.req1_ready_o} !== 2'b10) begin n_fail++; $display("FAIL abort_first_grant: got %b want 10", {bus.req0_ready_o, bus.req1_ready_o}); end
      tick;
      set_req0(1'b0, '0, '0, '0);
      set_req1(1'b0, '0, '0, '0);
      tick;
      @(negedge clk);
      n_checks++; if ({bus.rsp0_valid_o, bus.rsp1_valid_o, bus.rsp_data_o} !== {2'b10, 32'd2}) begin n_fail++; $display("FAIL abort_after_rsp: got %b%b %h want 10 2", bus.rsp0_valid_o, bus.rsp1_valid_o, bus.rsp_data_o); end
   endtask

   task automatic test_single_cycle_codes;
      logic [2:0]  ctrl_v [4];
      logic [31:0] a_v    [4];
      logic [31:0] b_v    [4];
      logic [31:0] exp_v  [4];
      ctrl_v[0] = 3'b111; a_v[0] = 32'hA5A5; b_v[0] = 32'hFFFF; exp_v[0] = 32'h5A5A;
      ctrl_v[1] = 3'b101; a_v[1] = 32'h1;    b_v[1] = 32'd4;    exp_v[1] = 32'h10;
      ctrl_v[2] = 3'b110; a_v[2] = 32'h80;   b_v[2] = 32'd3;    exp_v[2] = 32'h10;
      ctrl_v[3] = 3'b111; a_v[3] = 32'h1234; b_v[3] = 32'h1234; exp_v[3] = 32'h0;
      for (int n = 0; n < 4; n++) begin
         tick;
         set_req1(1'b1, a_v[n], b_v[n], ctrl_v[n]);
         @(negedge clk);
         n_checks++; if (bus.req1_ready_o !== 1'b1) begin n_fail++; $display("FAIL sc%0d_ready: got %b want 1", n, bus.req1_ready_o); end
         tick;
         set_req1(1'b0, '0, '0, '0);
         @(negedge clk);
         n_checks++; if ({bus.busy_o, bus.rsp1_valid_o} !== 2'b10) begin n_fail++; $display("FAIL sc%0d_exec: busy/rsp1 got %b want 10", n, {bus.busy_o, bus.rsp1_valid_o}); end
         tick;
         @(negedge clk);
         n_checks++; if ({bus.busy_o, bus.rsp1_valid_o} !== 2'b01) begin n_fail++; $display("FAIL sc%0d_done: busy/rsp1 got %b want 01", n, {bus.busy_o, bus.rsp1_valid_o}); end
         n_checks++; if ({bus.rsp_zero_o, bus.rsp_data_o} !== {(exp_v[n] == 32'd0), exp_v[n]}) begin n_fail++; $display("FAIL sc%0d_data: got %b %h want %h", n, bus.rsp_zero_o, bus.rsp_data_o, exp_v[n]); end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset;
      test_round_robin;
      test_multiply;
      test_back_to_back;
      test_reset_mid_mul;
      test_single_cycle_codes;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (32-bit operands, 3-bit ALU control, 32-bit result) between two requesters, e.g. the main execute path and a secondary address/iterative unit.
- Arbitrates round-robin, registers the winning operands, and holds them on the ALU inputs for the op's latency.
- Multiply (ctrl 3'b100) is treated as a multi-cycle op.
- Captures the ALU result into a response register and pulses a per-requester response valid.

Parameters:
- MUL_LAT, 3: cycles the ALU is held for a multiply; legal range 1..16.
- CNT_W, 4: width of the latency down-counter; must satisfy 2^CNT_W > MUL_LAT.

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  asynchronous, active-high reset
- req0_valid_i  input  1  requester 0 has an op pending
- req0_ready_o  output  1  requester 0's op is accepted this cycle
- req0_data1_i  input  32  requester 0 operand 1
- req0_data2_i  input  32  requester 0 operand 2
- req0_ctrl_i  input  3  requester 0 ALU control code
- req1_valid_i  input  1  requester 1 has an op pending
- req1_ready_o  output  1  requester 1's op is accepted this cycle
- req1_data1_i  input  32  requester 1 operand 1
- req1_data2_i  input  32  requester 1 operand 2
- req1_ctrl_i  input  3  requester 1 ALU control code
- alu_data1_o  output  32  registered operand 1 to the ALU
- alu_data2_o  output  32  registered operand 2 to the ALU
- alu_ctrl_o  output  3  registered control to the ALU
- alu_result_i  input  32  ALU result, combinational from alu_*_o
- rsp0_valid_o  output  1  one-cycle pulse: result for requester 0 is ready
- rsp1_valid_o  output  1  one-cycle pulse: result for requester 1 is ready
- rsp_data_o  output  32  registered result
- rsp_zero_o  output  1  registered flag, (result == 0)
- busy_o  output  1  high while the state is EXEC

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; alu_data1_o, alu_data2_o, alu_ctrl_o, rsp_data_o = 0.
  - rsp_zero_o=0, rsp*_valid_o=0, counter=0.
  - last_grant=1, so requester 0 wins the first tie.
  - Reset asserted mid-EXEC aborts the op; no response is ever issued for it.
- States: IDLE, EXEC.
- IDLE:
  - Grant: if exactly one valid, grant it. If both valid, grant the requester opposite last_grant.
  - reqN_ready_o = IDLE & grantN, combinational. Ready is never high outside IDLE, and never high for both requesters.
  - Accept (valid&ready): capture operands and ctrl into alu_*_o; last_grant <= winner; owner <= winner.
  - Load counter = (ctrl==3'b100) ? MUL_LAT-1 : 0, then go to EXEC.
- EXEC:
  - busy_o=1; alu_*_o are held stable.
  - If counter != 0: decrement.
  - If counter == 0, at that edge: rsp_data_o <= alu_result_i; rsp_zero_o <= (alu_result_i==0); rsp(owner)_valid_o <= 1; go to IDLE.
- rsp*_valid_o is a single-cycle pulse; it is cleared on every other edge.
- rsp_data_o and rsp_zero_o hold until the next completion.
- alu_*_o keep the last op's values while IDLE (no toggling without an accept).
- Latency: an op accepted in cycle c gets its response pulse in cycle c+2 for non-multiply ops, and c+1+MUL_LAT for multiply. MUL_LAT=1 gives multiply the same timing as other ops.
- Throughput: at most one accept per 2 cycles. A new accept may occur in the same cycle as a rsp pulse.
- All control codes other than 3'b100 (including 3'b111) are single-cycle.
- Requesters must hold valid, operands and ctrl stable until ready. The arbiter samples only on accept.
- A valid that drops before being granted is simply not serviced; no state is affected.

Test Plan:
- Reset during idle, then release:
  - Outputs: all outputs 0, state IDLE.
  - Request: req0 valid with add 5+7 (ctrl 000) accepted in cycle c.
  - Response: in cycle c+2, rsp0_valid_o=1, rsp_data_o=12, rsp_zero_o=0. rsp1_valid_o stays 0.
- Both valid continuously with sub ops (req0 9-9, req1 20-3):
  - Grant order: req0, req1, req0, req1.
  - Responses: rsp_data_o alternates 0 (rsp_zero_o=1) and 17, on the matching rsp*_valid_o.
- req1 multiply 6*7 with MUL_LAT=3, accepted in cycle c:
  - Hold: busy_o=1 for cycles c+1..c+3; alu_*_o stable; req0 valid gets no ready during this window.
  - Response: rsp1_valid_o=1 in cycle c+4 with rsp_data_o=42.
  - Follow-on: req0 is accepted in cycle c+4.
- Back-to-back single requester (req0, xor 0xFF^0x0F then and 0xF0&0x3C):
  - Accepts occur every 2nd cycle.
  - Results 0xF0 then 0x30.
  - Each rsp0_valid_o pulse lasts exactly 1 cycle.
- Reset asserted mid-multiply:
  - No rsp*_valid_o pulse for the aborted op.
  - After release: last_grant=1; with both requesters valid, req0 is granted first.
- Single-cycle ops sharing ctrl 111, plus shifts (101, 110):
  - Each completes in c+2, not c+1+MUL_LAT.
  - rsp_data_o equals alu_result_i as sampled at the completing edge.
